// File: rtl/red_pitaya_hk_pkg.sv
// Housekeeping package: shared types and constants for the DNA sequencer and
// related housekeeping blocks.
//   dna_state_e  - DNA sequencer states
//   DNA_W_DEF    - default device DNA width
//   SIM_DNA_DEF  - DNA value returned by the simulation model of DNA_PORT
package red_pitaya_hk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } dna_state_e;

  localparam int unsigned DNA_W_DEF = 57;
  localparam logic [DNA_W_DEF-1:0] SIM_DNA_DEF = 57'h0823456789ABCDE;

endpackage

// File: rtl/red_pitaya_clk_tick.sv
// Divider producing a one-cycle tick every DIV enabled cycles.
//   clk_i  - system clock
//   rstn_i - asynchronous active-low reset
//   clr_i  - synchronous clear of the counter (wins over en_i)
//   en_i   - count enable
//   tick_o - high while the counter is at DIV-1 and enabled
module red_pitaya_clk_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/red_pitaya_dna_ctrl.sv
// Sequencer for the Xilinx DNA_PORT primitive: generates the slow DNA clock and
// READ/SHIFT controls, shifts the device DNA in MSB first and holds the result.
//   clk_i, rstn_i  - system clock, asynchronous active-low reset
//   start_i        - (re)read request, honoured in idle/done only
//   busy_o         - read in progress
//   done_o         - one-cycle pulse when a read completes
//   valid_o        - dna_o holds a complete read
//   dna_o          - captured DNA
//   dna_clk_o, dna_read_o, dna_shift_o, dna_din_o - to DNA_PORT
//   dna_dout_i     - from DNA_PORT
module red_pitaya_dna_ctrl
  import red_pitaya_hk_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter int unsigned DNA_W      = DNA_W_DEF,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             valid_o,
  output logic [DNA_W-1:0] dna_o,
  output logic             dna_clk_o,
  output logic             dna_read_o,
  output logic             dna_shift_o,
  output logic             dna_din_o,
  input  logic             dna_dout_i
);

  localparam int unsigned BitW = $clog2(DNA_W + 1);

  dna_state_e       state_q, state_d;
  logic             first_q;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DNA_W-1:0] shreg_q, shreg_d;
  logic [DNA_W-1:0] dna_q, dna_d;
  logic             clk_q, clk_d;
  logic             read_q, read_d;
  logic             shift_q, shift_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             busy;
  logic             tick;
  logic             cnt_clr;

  assign busy    = (state_q == StLoad) || (state_q == StShift);
  // Restart the divider on every entry to LOAD so the first DNA clock high
  // phase is a full DIV cycles away from the accepting edge.
  assign cnt_clr = (state_d == StLoad) && (state_q != StLoad);

  red_pitaya_clk_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (cnt_clr),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dna_d     = dna_q;
    clk_d     = clk_q;
    unique case (state_q)
      StIdle: begin
        if (start_i || (AUTO_START && first_q)) state_d = StLoad;
      end
      StLoad: begin
        if (tick) begin
          clk_d = ~clk_q;
          if (clk_q) begin
            bit_cnt_d = '0;
            state_d   = StShift;
          end
        end
      end
      StShift: begin
        if (tick) begin
          if (!clk_q) begin
            // DOUT is taken just before the rising edge that advances DNA_PORT.
            shreg_d   = {shreg_q[DNA_W-2:0], dna_dout_i};
            bit_cnt_d = bit_cnt_q + BitW'(1);
            clk_d     = 1'b1;
          end else begin
            clk_d = 1'b0;
            if (bit_cnt_q == BitW'(DNA_W)) begin
              dna_d   = shreg_q;
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (start_i) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase

    read_d  = (state_d == StLoad);
    shift_d = (state_d == StShift);
    done_d  = (state_d == StDone) && (state_q != StDone);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      first_q   <= 1'b1;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dna_q     <= '0;
      clk_q     <= 1'b0;
      read_q    <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= 1'b0;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dna_q     <= dna_d;
      clk_q     <= clk_d;
      read_q    <= read_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o      = busy;
  assign done_o      = done_q;
  assign valid_o     = valid_q;
  assign dna_o       = dna_q;
  assign dna_clk_o   = clk_q;
  assign dna_read_o  = read_q;
  assign dna_shift_o = shift_q;
  assign dna_din_o   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_dna_ctrl.sv
// Directed bench for red_pitaya_dna_ctrl with a behavioural DNA_PORT model per
// instance (A: DIV=4 auto-start, B: DIV=2 manual start).
module tb_red_pitaya_dna_ctrl;
  import red_pitaya_hk_pkg::*;

  localparam int unsigned W = DNA_W_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A
  logic         rstn_a, start_a, busy_a, done_a, valid_a;
  logic [W-1:0] dna_a;
  logic         dclk_a, dread_a, dshift_a, ddin_a, ddout_a;
  // Instance B
  logic         rstn_b, start_b, busy_b, done_b, valid_b;
  logic [W-1:0] dna_b;
  logic         dclk_b, dread_b, dshift_b, ddin_b, ddout_b;

  red_pitaya_dna_ctrl #(.DIV(4), .DNA_W(W), .AUTO_START(1'b1)) dut_a (
    .clk_i(clk), .rstn_i(rstn_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .valid_o(valid_a), .dna_o(dna_a), .dna_clk_o(dclk_a), .dna_read_o(dread_a),
    .dna_shift_o(dshift_a), .dna_din_o(ddin_a), .dna_dout_i(ddout_a)
  );

  red_pitaya_dna_ctrl #(.DIV(2), .DNA_W(W), .AUTO_START(1'b0)) dut_b (
    .clk_i(clk), .rstn_i(rstn_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .valid_o(valid_b), .dna_o(dna_b), .dna_clk_o(dclk_b), .dna_read_o(dread_b),
    .dna_shift_o(dshift_b), .dna_din_o(ddin_b), .dna_dout_i(ddout_b)
  );

  // DNA_PORT models: load on CLK rise with READ, shift left on CLK rise with SHIFT.
  logic [W-1:0] sim_a, sim_b, mreg_a, mreg_b;
  always @(posedge dclk_a) begin
    if (dread_a) mreg_a <= sim_a;
    else if (dshift_a) mreg_a <= {mreg_a[W-2:0], 1'b0};
  end
  always @(posedge dclk_b) begin
    if (dread_b) mreg_b <= sim_b;
    else if (dshift_b) mreg_b <= {mreg_b[W-2:0], 1'b0};
  end
  assign ddout_a = mreg_a[W-1];
  assign ddout_b = mreg_b[W-1];

  // Scoreboards: expected DNA pushed at read start, popped at done_o.
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  // DNA clock monitor for A: rise counts per phase, overlap, high/low widths.
  logic mon_clr;
  int   rise_rd_a, rise_sh_a, overlap_a, run_a;
  int   hi_min, hi_max, lo_min, lo_max;
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (mon_clr) begin
      rise_rd_a = 0; rise_sh_a = 0; overlap_a = 0; run_a = 0;
      hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    end else begin
      if (dread_a && dshift_a) overlap_a++;
      if (dclk_a && !prev_a) begin
        if (dread_a) rise_rd_a++;
        if (dshift_a) rise_sh_a++;
      end
      if (!busy_a) run_a = 0;
      else if (run_a == 0 || dclk_a == prev_a) run_a++;
      else begin
        if (prev_a) begin
          if (run_a < hi_min) hi_min = run_a;
          if (run_a > hi_max) hi_max = run_a;
        end else begin
          if (run_a < lo_min) lo_min = run_a;
          if (run_a > lo_max) lo_max = run_a;
        end
        run_a = 1;
      end
    end
    prev_a = dclk_a;
  end

  int   rise_b = 0;
  logic prev_b = 1'b0;
  always @(negedge clk) begin
    if (dclk_b && !prev_b) rise_b++;
    prev_b = dclk_b;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done_a counting cycles from the LOAD-entry edge; optionally pokes
  // start_a for one cycle at cycle poke_at.
  task automatic wait_done_a(input int limit, input int poke_at, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      start_a = (n == poke_at);
      if (done_a) begin
        cyc = n;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic wait_done_b(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if (done_b) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic pop_check_a(input string tag);
    logic [W-1:0] e;
    if (exp_a_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_a_q.size()), 64'd1);
    end else begin
      e = exp_a_q.pop_front();
      check(tag, 64'(dna_a), 64'(e));
    end
  endtask

  task automatic start_pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  initial begin
    int           cyc;
    int           extra_done;
    logic [W-1:0] ones;
    ones = '1;
    mon_clr = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    rstn_a = 1'b0; rstn_b = 1'b0;
    sim_a = SIM_DNA_DEF; sim_b = SIM_DNA_DEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ctl", 64'({busy_a, done_a, valid_a, dclk_a, dread_a, dshift_a, ddin_a}), 64'd0);
    check("rst_a_dna", 64'(dna_a), 64'd0);
    check("rst_b_ctl", 64'({busy_b, done_b, valid_b, dclk_b, dread_b, dshift_b, ddin_b}), 64'd0);
    check("rst_b_dna", 64'(dna_b), 64'd0);

    // 1/2: auto-start read after reset release.
    @(negedge clk);
    mon_clr = 1'b0;
    rstn_a = 1'b1; rstn_b = 1'b1;
    @(posedge clk); #1;
    check("auto_busy", 64'({busy_a, dread_a, dshift_a}), 64'b110);
    exp_a_q.push_back(sim_a);
    wait_done_a(600, 0, cyc);
    check("t1_latency", 64'(cyc), 64'd464);
    pop_check_a("t1_dna");
    check("t1_valid", 64'({valid_a, busy_a}), 64'b10);
    check("t2_rise_read", 64'(rise_rd_a), 64'd1);
    check("t2_rise_shift", 64'(rise_sh_a), 64'd57);
    check("t2_overlap", 64'(overlap_a), 64'd0);
    check("t2_width", 64'({8'(hi_min), 8'(hi_max), 8'(lo_min), 8'(lo_max)}), 64'h04040404);
    @(posedge clk); #1;
    check("t1_done_pulse", 64'({done_a, valid_a}), 64'b01);
    check("t6_b_idle", 64'({busy_b, dread_b, dshift_b}), 64'd0);
    check("t6_b_no_clk", 64'(rise_b), 64'd0);

    // 3: start while busy is ignored and not queued.
    start_pulse_a();
    exp_a_q.push_back(sim_a);
    wait_done_a(600, 100, cyc);
    check("t3_latency", 64'(cyc), 64'd464);
    pop_check_a("t3_dna");
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a) extra_done++;
    end
    check("t3_no_requeue", 64'({8'(extra_done), 7'd0, busy_a}), 64'd0);
    check("t3_valid_hold", 64'(valid_a), 64'd1);

    // 4: re-read from DONE with a new model value.
    sim_a = ones;
    start_pulse_a();
    check("t4_valid_drop", 64'({valid_a, busy_a}), 64'b01);
    exp_a_q.push_back(sim_a);
    wait_done_a(600, 0, cyc);
    check("t4_latency", 64'(cyc), 64'd464);
    pop_check_a("t4_dna");

    // 5: asynchronous reset mid-SHIFT (around bit 20), then auto restart.
    start_pulse_a();
    repeat (168) @(posedge clk);
    #2;
    check("t5_in_shift", 64'(dshift_a), 64'd1);
    #1 rstn_a = 1'b0;
    #1;
    check("t5_abort_ctl", 64'({busy_a, done_a, valid_a, dclk_a, dread_a, dshift_a, ddin_a}), 64'd0);
    check("t5_abort_dna", 64'(dna_a), 64'd0);
    sim_a = SIM_DNA_DEF;
    @(negedge clk);
    rstn_a = 1'b1;
    @(posedge clk); #1;
    check("t5_restart", 64'({busy_a, dread_a}), 64'b11);
    exp_a_q.push_back(sim_a);
    wait_done_a(600, 0, cyc);
    check("t5_latency", 64'(cyc), 64'd464);
    pop_check_a("t5_dna");

    // 6: DIV=2 manual start.
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    exp_b_q.push_back(sim_b);
    wait_done_b(300, cyc);
    check("t6_latency", 64'(cyc), 64'd232);
    if (exp_b_q.size() != 0) check("t6_dna", 64'(dna_b), 64'(exp_b_q.pop_front()));
    check("t6_valid", 64'(valid_b), 64'd1);
    check("t6_rises", 64'(rise_b), 64'd58);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
